// File: rtl/objects_pkg.sv
// Shared types for the object bitmap stages: edge codes, coordinates and
// the collision detector state encoding.
package objects_pkg;

   typedef logic [3:0]  edge_code_t;
   typedef logic [10:0] coord_t;

   localparam int unsigned EDGE_LEFT   = 3;
   localparam int unsigned EDGE_TOP    = 2;
   localparam int unsigned EDGE_RIGHT  = 1;
   localparam int unsigned EDGE_BOTTOM = 0;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_FLUSH = 1'b1
   } coll_state_t;

endpackage

// File: rtl/frame_hit_accumulator.sv
// Per-frame collision evidence: saturating overlap count, OR of edge codes
// and the coordinate of the first overlap pixel.
import objects_pkg::*;

module frame_hit_accumulator #(
   parameter int unsigned COUNT_W = 12
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               clear,
   input  logic               hit,
   input  edge_code_t         hitEdgeCode,
   input  coord_t             hitX,
   input  coord_t             hitY,
   output edge_code_t         accEdge,
   output logic [COUNT_W-1:0] accCount,
   output coord_t             accFirstX,
   output coord_t             accFirstY
);

   logic accSeen;

   // Clear wins, but a hit in the clear cycle seeds the fresh frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         accEdge   <= '0;
         accCount  <= '0;
         accFirstX <= '0;
         accFirstY <= '0;
         accSeen   <= 1'b0;
      end else if (clear) begin
         accEdge   <= hit ? hitEdgeCode : '0;
         accCount  <= hit ? COUNT_W'(1) : '0;
         accFirstX <= hit ? hitX : '0;
         accFirstY <= hit ? hitY : '0;
         accSeen   <= hit;
      end else if (hit) begin
         accEdge <= accEdge | hitEdgeCode;
         if (accCount != '1) begin
            accCount <= accCount + COUNT_W'(1);
         end
         if (!accSeen) begin
            accFirstX <= hitX;
            accFirstY <= hitY;
            accSeen   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/stone_collision_frame_detector.sv
// Collects stone/player overlap evidence over a frame and publishes one
// report per frame at the next startOfFrame, with a valid/ack handshake.
import objects_pkg::*;

module stone_collision_frame_detector #(
   parameter int unsigned COUNT_W        = 12,
   parameter int unsigned MIN_HIT_PIXELS = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   input  logic               stoneDrawingRequest,
   input  logic [3:0]         stoneHitEdgeCode,
   input  logic               playerDrawingRequest,
   input  logic               collisionAck,
   output logic               collisionValid,
   output logic [3:0]         collisionEdgeCode,
   output logic [COUNT_W-1:0] collisionCount,
   output logic [10:0]        firstHitX,
   output logic [10:0]        firstHitY,
   output logic               reportOverrun
);

   coord_t             pixXd, pixYd;
   logic               overlap;
   edge_code_t         accEdge;
   logic [COUNT_W-1:0] accCount;
   coord_t             accFirstX, accFirstY;
   coll_state_t        state_q, state_d;
   logic               valid_d, overrun_d, load_report;

   assign overlap = stoneDrawingRequest & playerDrawingRequest;

   // Delay scan coordinates to line up with the registered bitmap requests.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pixXd <= '0;
         pixYd <= '0;
      end else begin
         pixXd <= pixelX;
         pixYd <= pixelY;
      end
   end

   frame_hit_accumulator #(
      .COUNT_W (COUNT_W)
   ) u_acc (
      .clk         (clk),
      .resetN      (resetN),
      .clear       (startOfFrame),
      .hit         (overlap),
      .hitEdgeCode (stoneHitEdgeCode),
      .hitX        (pixXd),
      .hitY        (pixYd),
      .accEdge     (accEdge),
      .accCount    (accCount),
      .accFirstX   (accFirstX),
      .accFirstY   (accFirstY)
   );

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_q <= ST_ACCUM;
      else         state_q <= state_d;
   end

   // Next state and handshake. The flush work is done on the edge that
   // enters FLUSH so the report lands one cycle after startOfFrame; FLUSH
   // is then the first accumulating cycle of the new frame.
   always_comb begin
      state_d     = state_q;
      valid_d     = collisionValid;
      overrun_d   = reportOverrun;
      load_report = 1'b0;
      case (state_q)
         ST_ACCUM: if (startOfFrame) state_d = ST_FLUSH;
         ST_FLUSH: state_d = startOfFrame ? ST_FLUSH : ST_ACCUM;
         default:  state_d = ST_ACCUM;
      endcase
      if (collisionValid && collisionAck) valid_d = 1'b0;
      if (startOfFrame && (accCount >= COUNT_W'(MIN_HIT_PIXELS))) begin
         load_report = 1'b1;
         valid_d     = 1'b1;
         if (collisionValid && !collisionAck) overrun_d = 1'b1;
      end
   end

   // Report registers, held stable until the next qualifying flush.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         collisionValid    <= 1'b0;
         reportOverrun     <= 1'b0;
         collisionEdgeCode <= '0;
         collisionCount    <= '0;
         firstHitX         <= '0;
         firstHitY         <= '0;
      end else begin
         collisionValid <= valid_d;
         reportOverrun  <= overrun_d;
         if (load_report) begin
            collisionEdgeCode <= accEdge;
            collisionCount    <= accCount;
            firstHitX         <= accFirstX;
            firstHitY         <= accFirstY;
         end
      end
   end

endmodule

// File: tb/tb_stone_collision_frame_detector.sv
// Scoreboard bench for stone_collision_frame_detector: the driver keeps a
// per-frame list of overlap pixels and pushes the expected report state on
// every flush/ack event; the monitor pops and compares on each DUT event.
module tb_stone_collision_frame_detector;

   localparam int unsigned CW   = 12;
   localparam int unsigned MINH = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetN;
   logic          startOfFrame;
   logic [10:0]   pixelX, pixelY;
   logic          stoneDrawingRequest, playerDrawingRequest;
   logic [3:0]    stoneHitEdgeCode;
   logic          collisionAck;
   logic          collisionValid;
   logic [3:0]    collisionEdgeCode;
   logic [CW-1:0] collisionCount;
   logic [10:0]   firstHitX, firstHitY;
   logic          reportOverrun;

   stone_collision_frame_detector #(
      .COUNT_W        (CW),
      .MIN_HIT_PIXELS (MINH)
   ) dut (
      .clk                  (clk),
      .resetN               (resetN),
      .startOfFrame         (startOfFrame),
      .pixelX               (pixelX),
      .pixelY               (pixelY),
      .stoneDrawingRequest  (stoneDrawingRequest),
      .stoneHitEdgeCode     (stoneHitEdgeCode),
      .playerDrawingRequest (playerDrawingRequest),
      .collisionAck         (collisionAck),
      .collisionValid       (collisionValid),
      .collisionEdgeCode    (collisionEdgeCode),
      .collisionCount       (collisionCount),
      .firstHitX            (firstHitX),
      .firstHitY            (firstHitY),
      .reportOverrun        (reportOverrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [3:0]    ecode;
      logic [CW-1:0] cnt;
      logic [10:0]   fx;
      logic [10:0]   fy;
      logic          ovr;
   } exp_t;

   exp_t expq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: overlap pixels of the frame in progress.
   int unsigned hx[$];
   int unsigned hy[$];
   int unsigned hcode[$];
   exp_t        m;
   logic [10:0] prev_x, prev_y;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      hx.delete(); hy.delete(); hcode.delete();
      m = '{valid: 1'b0, ecode: '0, cnt: '0, fx: '0, fy: '0, ovr: 1'b0};
      prev_x = '0;
      prev_y = '0;
   endtask

   // One pixel cycle: drive inputs and advance the model.
   task automatic drive(input logic sof, input logic sreq, input logic preq,
                        input logic [3:0] code, input logic ack,
                        input logic [10:0] x, input logic [10:0] y);
      logic        was_valid;
      int unsigned orv;
      @(negedge clk);
      startOfFrame         = sof;
      stoneDrawingRequest  = sreq;
      playerDrawingRequest = preq;
      stoneHitEdgeCode     = code;
      collisionAck         = ack;
      pixelX               = x;
      pixelY               = y;
      was_valid = m.valid;
      if (m.valid && ack) m.valid = 1'b0;
      if (sof) begin
         if (hx.size() >= MINH) begin
            if (was_valid && !ack) m.ovr = 1'b1;
            m.valid = 1'b1;
            m.cnt   = CW'((hx.size() > CMAX) ? CMAX : hx.size());
            orv = 0;
            foreach (hcode[i]) orv |= hcode[i];
            m.ecode = 4'(orv);
            m.fx    = 11'(hx[0]);
            m.fy    = 11'(hy[0]);
         end
         hx.delete(); hy.delete(); hcode.delete();
      end
      if (sreq && preq) begin
         hx.push_back(prev_x);
         hy.push_back(prev_y);
         hcode.push_back(code);
      end
      prev_x = x;
      prev_y = y;
      if (sof || (was_valid && ack)) expq.push_back(m);
   endtask

   task automatic idle(input int n, input logic ack);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, ack, 11'd0, 11'd0);
   endtask

   task automatic hits(input int n, input logic [3:0] code, input logic [10:0] x0, input logic [10:0] y);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, code, 1'b0, 11'(x0 + 11'(i)), y);
   endtask

   task automatic sof_pulse(input logic ack);
      drive(1'b1, 1'b0, 1'b0, 4'h0, ack, 11'd0, 11'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid",   32'(collisionValid),    32'd0);
      chk("rst_edge",    32'(collisionEdgeCode), 32'd0);
      chk("rst_count",   32'(collisionCount),    32'd0);
      chk("rst_fx",      32'(firstHitX),         32'd0);
      chk("rst_fy",      32'(firstHitY),         32'd0);
      chk("rst_overrun", 32'(reportOverrun),     32'd0);
   endtask

   task automatic apply_reset();
      idle(1, 1'b0);
      @(negedge clk);
      resetN = 1'b0;
      startOfFrame = 1'b0; stoneDrawingRequest = 1'b0; playerDrawingRequest = 1'b0;
      stoneHitEdgeCode = '0; collisionAck = 1'b0; pixelX = '0; pixelY = '0;
      #1;
      check_reset_outputs();
      model_clear();
      expq.delete();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   // Monitor: an event is a flush or an accepted ack; compare one edge later.
   logic evt;
   exp_t me;
   always @(posedge clk or negedge resetN) begin
      if (!resetN) evt <= 1'b0;
      else         evt <= startOfFrame || (collisionValid && collisionAck);
   end

   always @(negedge clk) begin
      if (evt && resetN) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: DUT event with no expected entry at %0t", $time);
         end else begin
            me = expq.pop_front();
            chk("valid",   32'(collisionValid),    32'(me.valid));
            chk("edge",    32'(collisionEdgeCode), 32'(me.ecode));
            chk("count",   32'(collisionCount),    32'(me.cnt));
            chk("firstX",  32'(firstHitX),         32'(me.fx));
            chk("firstY",  32'(firstHitY),         32'(me.fy));
            chk("overrun", 32'(reportOverrun),     32'(me.ovr));
         end
      end
   end

   initial begin
      resetN = 1'b0;
      startOfFrame = 1'b0; stoneDrawingRequest = 1'b0; playerDrawingRequest = 1'b0;
      stoneHitEdgeCode = '0; collisionAck = 1'b0; pixelX = '0; pixelY = '0;
      model_clear();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      resetN = 1'b1;

      // 6 hits, edges 8 then 2, first at delayed (100,200).
      sof_pulse(1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 11'd100, 11'd200);
      drive(1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 11'd101, 11'd200);
      hits(5, 4'h2, 11'd102, 11'd200);
      sof_pulse(1'b0);
      idle(1, 1'b1);

      // Below threshold: no report.
      hits(3, 4'h4, 11'd10, 11'd20);
      sof_pulse(1'b0);
      idle(2, 1'b0);

      // Ack in the flush cycle: new report wins, no overrun.
      hits(5, 4'h1, 11'd30, 11'd40);
      sof_pulse(1'b0);
      hits(5, 4'h4, 11'd50, 11'd60);
      sof_pulse(1'b1);

      // Unacked report replaced: overrun.
      hits(5, 4'h8, 11'd70, 11'd80);
      sof_pulse(1'b0);
      idle(1, 1'b1);

      // Overlap coincident with startOfFrame belongs to the new frame.
      hits(4, 4'h2, 11'd300, 11'd301);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 11'd555, 11'd666);
      drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 11'd556, 11'd666);
      hits(3, 4'h4, 11'd557, 11'd666);
      idle(1, 1'b1);
      sof_pulse(1'b0);
      idle(1, 1'b1);

      // Saturation of the overlap counter.
      hits(int'(CMAX) + 5, 4'h2, 11'd0, 11'd5);
      sof_pulse(1'b0);
      idle(1, 1'b1);

      // Reset mid-frame after 10 overlaps; next frame reports only its own.
      sof_pulse(1'b0);
      hits(10, 4'hF, 11'd1, 11'd2);
      apply_reset();
      sof_pulse(1'b0);
      hits(4, 4'h2, 11'd400, 11'd401);
      sof_pulse(1'b0);
      idle(1, 1'b1);

      // Randomised frames, including back-to-back and empty frames.
      for (int f = 0; f < 250; f++) begin
         int unsigned len;
         len = $urandom_range(0, 30);
         for (int unsigned c = 0; c < len; c++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  4'($urandom), 1'($urandom_range(0, 5) == 0),
                  11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
         end
         drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom), 1'($urandom_range(0, 2) == 0),
               11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
      end

      idle(3, 1'b1);
      idle(2, 1'b0);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
